// File: rtl/rr_arb8_ctrl.sv
// rr_arb8_ctrl: round-robin arbiter and sequencer that shares one 8:1 mux
// among eight requesters. It drives the mux selects s2/s1/s0 from a flop,
// issues one-hot grants and limits how long one requester may hold the mux.
//
// Handshake: req[i] is a level request. Once gnt[i] is seen high, the mux
// output belongs to requester i. It keeps ownership while req[i] stays high,
// for at most HOLD_MAX consecutive cycles. A grant is never preempted by
// another requester. A request that drops before it is granted leaves no
// trace.
module rr_arb8_ctrl #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic [2:0] owner,
  output logic       dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       last_ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic             win_found;
  logic [2:0]       win_idx;
  logic             keep;

  // The round-robin search starts just after last_ptr and wraps.
  // last_ptr itself is tried last, which lets a lone owner be re-granted.
  always_comb begin
    logic [2:0] idx;
    win_found = 1'b0;
    win_idx   = last_ptr;
    idx       = last_ptr;
    for (int k = 8; k >= 1; k--) begin
      idx = last_ptr + 3'(k);
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // The owner keeps the mux while it requests and its hold budget remains.
  always_comb begin
    keep = req[owner] && (hold_cnt < CNT_W'(HOLD_MAX - 1));
  end

  // This block holds the arbiter FSM and all of the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 8'd0;
      owner    <= 3'd0;
      valid    <= 1'b0;
      last_ptr <= 3'd7;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            gnt      <= 8'd1 << win_idx;
            owner    <= win_idx;
            valid    <= 1'b1;
            last_ptr <= win_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (keep) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else if (win_found) begin
            // Rotate back-to-back. In GRANT, last_ptr always equals owner.
            gnt      <= 8'd1 << win_idx;
            owner    <= win_idx;
            valid    <= 1'b1;
            last_ptr <= win_idx;
            hold_cnt <= '0;
          end else begin
            // Nobody is requesting. Go idle and keep the selects where they were.
            state    <= IDLE;
            gnt      <= 8'd0;
            valid    <= 1'b0;
            hold_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'd0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign s2        = owner[2];
  assign s1        = owner[1];
  assign s0        = owner[0];
  assign dbg_state = (state == GRANT);

endmodule
